aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
// Sequential AES-128 key schedule. Loads a 128-bit cipher key and streams round keys 0..NR, one per accepted
// valid/ready transfer, to the AddRoundKey stage that consumes the MixColumns output of each round.
// Byte order matches the round datapath: byte 0 at [127:120], column c occupies [127-32c -: 32], word w0 = [127:96].
// PARAMETERS
// NR  10  number of rounds; emits NR+1 round keys. Only 10 (AES-128) is supported; other values are an elaboration error.
// PORTS
// clk       in   1    clock, all state updates on rising edge
// rst       in   1    reset, asynchronous, active-high
// key_in    in   128  cipher key, sampled on the cycle key_load is accepted
// key_load  in   1    start request; accepted only in IDLE
// busy      out  1    high from the cycle after key acceptance until the cycle after the last key transfer
// rk_out    out  128  current round key (words w[4i..4i+3])
// rk_idx    out  4    round index i of rk_out, 0..NR
// rk_valid  out  1    rk_out/rk_idx hold a valid round key
// rk_ready  in   1    consumer accepts rk_out this cycle when rk_valid is also high
// done      out  1    one-cycle pulse in the cycle after round key NR is transferred
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; rk_out=0, rk_idx=0, rk_valid=0, busy=0, done=0, rcon=8'h01.
// - States: IDLE, STREAM.
//   IDLE: key_load=1 -> rk_out<=key_in, rk_idx<=0, rcon<=8'h01, rk_valid<=1, busy<=1, goto STREAM. Latency: key to
//     first valid = 1 cycle.
//   STREAM: rk_valid=1 throughout. On transfer (rk_valid&rk_ready):
//     rk_idx<NR  -> rk_out<=next_key(rk_out,rcon), rk_idx<=rk_idx+1, rcon<=xtime(rcon) (x2 mod 0x11b; 0x80->0x1b).
//     rk_idx==NR -> rk_valid<=0, busy<=0, done<=1 next cycle, goto IDLE. rk_out/rk_idx keep their last values.
//   No transfer: rk_out, rk_idx, rcon hold (stall of any length is lossless).
// - next_key: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; RotWord({a,b,c,d})={b,c,d,a};
//   w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. Entirely combinational from registered state; one key per cycle.
// - rcon sequence over keys 1..10: 01,02,04,08,10,20,40,80,1b,36.
// - key_load while STREAM is ignored (no restart, no error). key_load in the done cycle (state already IDLE) is
//   accepted normally, back-to-back with no idle gap.
// - done is registered and asserted for exactly one cycle; done and rk_valid are never high together.
// - rk_ready while rk_valid=0 has no effect.
// - Reset mid-stream aborts immediately; no done pulse; next key_load after release starts from round 0.
// - rk_out is registered; no combinational path from rk_ready or key_in to any output.
// STRUCTURE
// - Shared package aes_pkg: NR_AES128 = 10, RCON_INIT = 8'h01, xtime() function (also used by MixColumns),
//   state enum {IDLE, STREAM}, typedef of a 32-bit word and 128-bit state.
// - Sub-module aes_sbox: combinational 8-bit forward S-box (256-entry case table); instantiated 4x for SubWord.
//   The same sub-module serves the SubBytes stage.
// - Top: FSM, rk_idx counter, rcon register, rk_out register, next_key combinational logic.
// TESTING
// - FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605;
//   idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; 11 consecutive valid cycles; done 1 cycle after idx10 transfer.
// - All-zero key, rk_ready=1 -> idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
// - FIPS key with rk_ready toggled randomly (~50%) -> identical 11-key sequence, rk_out/rk_idx stable while stalled,
//   no key skipped or repeated.
// - key_load=1 with a different key during idx 3 of the FIPS stream -> stream unaffected, idx10 still d014f9a8...;
//   key_load held in done cycle -> new stream starts next cycle with idx0 = new key.
// - Assert rst while rk_idx=5, rk_valid=1 -> rk_valid, busy, done, rk_out, rk_idx go 0 asynchronously;
//   after release a fresh load of the FIPS key yields idx1 = a0fafe17... (rcon restarted at 01).
// - rk_ready=0 for 20 cycles after idx0 valid -> busy=1, rk_idx=0 held, done=0; then rk_ready=1 completes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule constants, word/state types and the GF(2^8) doubling
// used by both the key schedule (rcon) and MixColumns.
package aes_pkg;
    localparam int         NR_AES128 = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic {IDLE, STREAM} ks_state_e;

    // Registered round key as presented to AddRoundKey
    typedef struct packed {
        state_t     key;
        logic [3:0] idx;
    } rk_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational. Shared by SubWord (key schedule) and SubBytes.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    always_comb begin
        dout = 8'h00;
        case (din)
            8'h00: dout = 8'h63; 8'h01: dout = 8'h7c; 8'h02: dout = 8'h77; 8'h03: dout = 8'h7b; 8'h04: dout = 8'hf2; 8'h05: dout = 8'h6b; 8'h06: dout = 8'h6f; 8'h07: dout = 8'hc5;
            8'h08: dout = 8'h30; 8'h09: dout = 8'h01; 8'h0a: dout = 8'h67; 8'h0b: dout = 8'h2b; 8'h0c: dout = 8'hfe; 8'h0d: dout = 8'hd7; 8'h0e: dout = 8'hab; 8'h0f: dout = 8'h76;
            8'h10: dout = 8'hca; 8'h11: dout = 8'h82; 8'h12: dout = 8'hc9; 8'h13: dout = 8'h7d; 8'h14: dout = 8'hfa; 8'h15: dout = 8'h59; 8'h16: dout = 8'h47; 8'h17: dout = 8'hf0;
            8'h18: dout = 8'had; 8'h19: dout = 8'hd4; 8'h1a: dout = 8'ha2; 8'h1b: dout = 8'haf; 8'h1c: dout = 8'h9c; 8'h1d: dout = 8'ha4; 8'h1e: dout = 8'h72; 8'h1f: dout = 8'hc0;
            8'h20: dout = 8'hb7; 8'h21: dout = 8'hfd; 8'h22: dout = 8'h93; 8'h23: dout = 8'h26; 8'h24: dout = 8'h36; 8'h25: dout = 8'h3f; 8'h26: dout = 8'hf7; 8'h27: dout = 8'hcc;
            8'h28: dout = 8'h34; 8'h29: dout = 8'ha5; 8'h2a: dout = 8'he5; 8'h2b: dout = 8'hf1; 8'h2c: dout = 8'h71; 8'h2d: dout = 8'hd8; 8'h2e: dout = 8'h31; 8'h2f: dout = 8'h15;
            8'h30: dout = 8'h04; 8'h31: dout = 8'hc7; 8'h32: dout = 8'h23; 8'h33: dout = 8'hc3; 8'h34: dout = 8'h18; 8'h35: dout = 8'h96; 8'h36: dout = 8'h05; 8'h37: dout = 8'h9a;
            8'h38: dout = 8'h07; 8'h39: dout = 8'h12; 8'h3a: dout = 8'h80; 8'h3b: dout = 8'he2; 8'h3c: dout = 8'heb; 8'h3d: dout = 8'h27; 8'h3e: dout = 8'hb2; 8'h3f: dout = 8'h75;
            8'h40: dout = 8'h09; 8'h41: dout = 8'h83; 8'h42: dout = 8'h2c; 8'h43: dout = 8'h1a; 8'h44: dout = 8'h1b; 8'h45: dout = 8'h6e; 8'h46: dout = 8'h5a; 8'h47: dout = 8'ha0;
            8'h48: dout = 8'h52; 8'h49: dout = 8'h3b; 8'h4a: dout = 8'hd6; 8'h4b: dout = 8'hb3; 8'h4c: dout = 8'h29; 8'h4d: dout = 8'he3; 8'h4e: dout = 8'h2f; 8'h4f: dout = 8'h84;
            8'h50: dout = 8'h53; 8'h51: dout = 8'hd1; 8'h52: dout = 8'h00; 8'h53: dout = 8'hed; 8'h54: dout = 8'h20; 8'h55: dout = 8'hfc; 8'h56: dout = 8'hb1; 8'h57: dout = 8'h5b;
            8'h58: dout = 8'h6a; 8'h59: dout = 8'hcb; 8'h5a: dout = 8'hbe; 8'h5b: dout = 8'h39; 8'h5c: dout = 8'h4a; 8'h5d: dout = 8'h4c; 8'h5e: dout = 8'h58; 8'h5f: dout = 8'hcf;
            8'h60: dout = 8'hd0; 8'h61: dout = 8'hef; 8'h62: dout = 8'haa; 8'h63: dout = 8'hfb; 8'h64: dout = 8'h43; 8'h65: dout = 8'h4d; 8'h66: dout = 8'h33; 8'h67: dout = 8'h85;
            8'h68: dout = 8'h45; 8'h69: dout = 8'hf9; 8'h6a: dout = 8'h02; 8'h6b: dout = 8'h7f; 8'h6c: dout = 8'h50; 8'h6d: dout = 8'h3c; 8'h6e: dout = 8'h9f; 8'h6f: dout = 8'ha8;
            8'h70: dout = 8'h51; 8'h71: dout = 8'ha3; 8'h72: dout = 8'h40; 8'h73: dout = 8'h8f; 8'h74: dout = 8'h92; 8'h75: dout = 8'h9d; 8'h76: dout = 8'h38; 8'h77: dout = 8'hf5;
            8'h78: dout = 8'hbc; 8'h79: dout = 8'hb6; 8'h7a: dout = 8'hda; 8'h7b: dout = 8'h21; 8'h7c: dout = 8'h10; 8'h7d: dout = 8'hff; 8'h7e: dout = 8'hf3; 8'h7f: dout = 8'hd2;
            8'h80: dout = 8'hcd; 8'h81: dout = 8'h0c; 8'h82: dout = 8'h13; 8'h83: dout = 8'hec; 8'h84: dout = 8'h5f; 8'h85: dout = 8'h97; 8'h86: dout = 8'h44; 8'h87: dout = 8'h17;
            8'h88: dout = 8'hc4; 8'h89: dout = 8'ha7; 8'h8a: dout = 8'h7e; 8'h8b: dout = 8'h3d; 8'h8c: dout = 8'h64; 8'h8d: dout = 8'h5d; 8'h8e: dout = 8'h19; 8'h8f: dout = 8'h73;
            8'h90: dout = 8'h60; 8'h91: dout = 8'h81; 8'h92: dout = 8'h4f; 8'h93: dout = 8'hdc; 8'h94: dout = 8'h22; 8'h95: dout = 8'h2a; 8'h96: dout = 8'h90; 8'h97: dout = 8'h88;
            8'h98: dout = 8'h46; 8'h99: dout = 8'hee; 8'h9a: dout = 8'hb8; 8'h9b: dout = 8'h14; 8'h9c: dout = 8'hde; 8'h9d: dout = 8'h5e; 8'h9e: dout = 8'h0b; 8'h9f: dout = 8'hdb;
            8'ha0: dout = 8'he0; 8'ha1: dout = 8'h32; 8'ha2: dout = 8'h3a; 8'ha3: dout = 8'h0a; 8'ha4: dout = 8'h49; 8'ha5: dout = 8'h06; 8'ha6: dout = 8'h24; 8'ha7: dout = 8'h5c;
            8'ha8: dout = 8'hc2; 8'ha9: dout = 8'hd3; 8'haa: dout = 8'hac; 8'hab: dout = 8'h62; 8'hac: dout = 8'h91; 8'had: dout = 8'h95; 8'hae: dout = 8'he4; 8'haf: dout = 8'h79;
            8'hb0: dout = 8'he7; 8'hb1: dout = 8'hc8; 8'hb2: dout = 8'h37; 8'hb3: dout = 8'h6d; 8'hb4: dout = 8'h8d; 8'hb5: dout = 8'hd5; 8'hb6: dout = 8'h4e; 8'hb7: dout = 8'ha9;
            8'hb8: dout = 8'h6c; 8'hb9: dout = 8'h56; 8'hba: dout = 8'hf4; 8'hbb: dout = 8'hea; 8'hbc: dout = 8'h65; 8'hbd: dout = 8'h7a; 8'hbe: dout = 8'hae; 8'hbf: dout = 8'h08;
            8'hc0: dout = 8'hba; 8'hc1: dout = 8'h78; 8'hc2: dout = 8'h25; 8'hc3: dout = 8'h2e; 8'hc4: dout = 8'h1c; 8'hc5: dout = 8'ha6; 8'hc6: dout = 8'hb4; 8'hc7: dout = 8'hc6;
            8'hc8: dout = 8'he8; 8'hc9: dout = 8'hdd; 8'hca: dout = 8'h74; 8'hcb: dout = 8'h1f; 8'hcc: dout = 8'h4b; 8'hcd: dout = 8'hbd; 8'hce: dout = 8'h8b; 8'hcf: dout = 8'h8a;
            8'hd0: dout = 8'h70; 8'hd1: dout = 8'h3e; 8'hd2: dout = 8'hb5; 8'hd3: dout = 8'h66; 8'hd4: dout = 8'h48; 8'hd5: dout = 8'h03; 8'hd6: dout = 8'hf6; 8'hd7: dout = 8'h0e;
            8'hd8: dout = 8'h61; 8'hd9: dout = 8'h35; 8'hda: dout = 8'h57; 8'hdb: dout = 8'hb9; 8'hdc: dout = 8'h86; 8'hdd: dout = 8'hc1; 8'hde: dout = 8'h1d; 8'hdf: dout = 8'h9e;
            8'he0: dout = 8'he1; 8'he1: dout = 8'hf8; 8'he2: dout = 8'h98; 8'he3: dout = 8'h11; 8'he4: dout = 8'h69; 8'he5: dout = 8'hd9; 8'he6: dout = 8'h8e; 8'he7: dout = 8'h94;
            8'he8: dout = 8'h9b; 8'he9: dout = 8'h1e; 8'hea: dout = 8'h87; 8'heb: dout = 8'he9; 8'hec: dout = 8'hce; 8'hed: dout = 8'h55; 8'hee: dout = 8'h28; 8'hef: dout = 8'hdf;
            8'hf0: dout = 8'h8c; 8'hf1: dout = 8'ha1; 8'hf2: dout = 8'h89; 8'hf3: dout = 8'h0d; 8'hf4: dout = 8'hbf; 8'hf5: dout = 8'he6; 8'hf6: dout = 8'h42; 8'hf7: dout = 8'h68;
            8'hf8: dout = 8'h41; 8'hf9: dout = 8'h99; 8'hfa: dout = 8'h2d; 8'hfb: dout = 8'h0f; 8'hfc: dout = 8'hb0; 8'hfd: dout = 8'h54; 8'hfe: dout = 8'hbb; 8'hff: dout = 8'h16;
            default: dout = 8'h00;
        endcase
    end
endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule: loads the cipher key and streams round keys 0..NR over a
// valid/ready handshake, computing one new round key per accepted transfer.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);
    if (NR != NR_AES128) begin : g_nr_check
        $error("aes_key_expander: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e  state_q, state_d;
    rk_t        rk_q;
    logic [7:0] rcon_q;
    logic       valid_q, busy_q, done_q;
    logic       xfer, last;

    word_t  w0, w1, w2, w3, w3_rot, sub_w, t;
    word_t  n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_q.key;
    assign w3_rot = {w3[23:0], w3[31:24]};

    // SubWord: one S-box per byte of the rotated last column
    aes_sbox u_sbox [3:0] (
        .din  (w3_rot),
        .dout (sub_w)
    );

    assign t  = sub_w ^ {rcon_q, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign xfer = valid_q & rk_ready;
    assign last = (rk_q.idx == LAST_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_load)     state_d = STREAM;
            STREAM:  if (xfer && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_q    <= '0;
            rcon_q  <= RCON_INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_load) begin
                        rk_q.key <= key_in;
                        rk_q.idx <= 4'd0;
                        rcon_q   <= RCON_INIT;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                STREAM: begin
                    // Without a transfer everything holds, so stalls of any length are lossless
                    if (xfer) begin
                        if (last) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rk_q.key <= {n0, n1, n2, n3};
                            rk_q.idx <= rk_q.idx + 4'd1;
                            rcon_q   <= xtime(rcon_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rk_out   = rk_q.key;
    assign rk_idx   = rk_q.idx;
    assign rk_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: known-answer table plus random keys/backpressure against an
// arithmetic key-schedule model (S-box derived from GF(2^8) inversion and the affine map).
module tb_aes_key_expander;
    logic         clk = 1'b0;
    logic         rst, key_load, rk_ready, busy, rk_valid, done;
    logic [127:0] key_in, rk_out;
    logic [3:0]   rk_idx;

    always #5 clk = ~clk;

    aes_key_expander #(.NR(10)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .busy(busy),
        .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready), .done(done)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;

    int n_chk = 0, n_fail = 0, n_cyc;
    logic [7:0]   sb_tab [256];
    logic [127:0] got    [11];
    logic [127:0] exp_rk [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box(a) = affine(a^254), a^254 being the multiplicative inverse (0 maps to 0)
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
            b = inv;
            sb_tab[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // Word-array key expansion: w[i] = w[i-4] ^ f(w[i-1]); round key r = w[4r..4r+3]
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
                tmp ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called at a negedge. Collects keys 0..10 into got[], checks ordering, stall stability and
    // the done pulse; returns at the negedge of the done cycle.
    task automatic run_stream(input logic [127:0] key, input int pct, input bit do_load,
                              input int inj_idx, input logic [127:0] inj_key);
        int nxt; bit stalled, fin; logic [127:0] prev_out;
        nxt = 0; stalled = 0; fin = 0; n_cyc = 0; prev_out = '0;
        if (do_load) begin
            key_in = key; key_load = 1'b1;
            @(negedge clk);
            key_load = 1'b0;
        end
        while (!fin && n_cyc < 500) begin
            check("valid", rk_valid, 1);
            check("idx_order", rk_idx, nxt);
            check("busy", busy, 1);
            check("done_low", done, 0);
            if (stalled) check("stall_hold", rk_out, prev_out);
            key_load = (nxt == inj_idx);
            if (nxt == inj_idx) key_in = inj_key;
            rk_ready = ($urandom_range(99) < pct);
            prev_out = rk_out;
            if (rk_ready) begin got[nxt] = rk_out; nxt++; stalled = 0; end
            else stalled = 1;
            n_cyc++;
            @(negedge clk);
            if (nxt == 11) fin = 1;
        end
        key_load = 1'b0; rk_ready = 1'b0;
        if (!fin) check("stream_timeout", 0, 1);
        else begin
            check("done_pulse", done, 1);
            check("valid_off", rk_valid, 0);
            check("busy_off", busy, 0);
        end
    endtask

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] req;
        string        name;
    } vec_t;
    vec_t vt [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; key_load = 1'b0; rk_ready = 1'b0; key_in = '0;
        build_sbox();
        #12;
        check("rst_rk_out", rk_out, 0);
        check("rst_rk_idx", rk_idx, 0);
        check("rst_valid", rk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        vt[0] = '{FIPS_KEY, 0,  FIPS_KEY, "fips_idx0"};
        vt[1] = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_idx1"};
        vt[2] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_idx10"};
        vt[3] = '{128'h0,   1,  128'h62636363626363636263636362636363, "zero_idx1"};
        vt[4] = '{128'h0,   10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_idx10"};
        for (int i = 0; i < 5; i++) begin
            run_stream(vt[i].key, 100, 1, -1, '0);
            check(vt[i].name, got[vt[i].idx], vt[i].req);
            check("valid_cycles", n_cyc, 11);
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end

        // Random backpressure on the FIPS key, then random keys against the model
        expand(FIPS_KEY);
        run_stream(FIPS_KEY, 50, 1, -1, '0);
        for (int r = 0; r < 11; r++) check("fips_stall_rk", got[r], exp_rk[r]);
        for (int k = 0; k < 6; k++) begin
            logic [127:0] rk;
            rk = {$urandom, $urandom, $urandom, $urandom};
            expand(rk);
            run_stream(rk, 50, 1, -1, '0);
            for (int r = 0; r < 11; r++) check("rand_rk", got[r], exp_rk[r]);
        end

        // key_load mid-stream is ignored; key_load in the done cycle starts a new stream at once
        expand(FIPS_KEY);
        run_stream(FIPS_KEY, 100, 1, 3, KEY2);
        for (int r = 0; r < 11; r++) check("ignore_load_rk", got[r], exp_rk[r]);
        key_in = KEY2; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        check("b2b_valid", rk_valid, 1);
        check("b2b_idx", rk_idx, 0);
        check("b2b_key", rk_out, KEY2);
        check("b2b_done", done, 0);
        expand(KEY2);
        run_stream(KEY2, 100, 0, -1, '0);
        for (int r = 0; r < 11; r++) check("b2b_rk", got[r], exp_rk[r]);
        @(negedge clk);

        // Reset mid-stream at idx 5
        key_in = FIPS_KEY; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0; rk_ready = 1'b1;
        for (int c = 0; c < 20 && rk_idx != 4'd5; c++) @(negedge clk);
        check("pre_rst_idx", rk_idx, 5);
        rk_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", rk_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rk_out", rk_out, 0);
        check("arst_rk_idx", rk_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("no_done_after_rst", done, 0);
        run_stream(FIPS_KEY, 100, 1, -1, '0);
        check("post_rst_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("post_rst_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);

        // 20-cycle stall on idx 0
        key_in = FIPS_KEY; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0; rk_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("hold_busy", busy, 1);
            check("hold_idx", rk_idx, 0);
            check("hold_done", done, 0);
            check("hold_out", rk_out, FIPS_KEY);
            @(negedge clk);
        end
        run_stream(FIPS_KEY, 100, 0, -1, '0);
        check("hold_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
